// File: rtl/button_step_gen.sv
// button_step_gen
//   Turns the raw up/down push-buttons into clean single-cycle step pulses for an
//   up/down stepper (e.g. the colour-index selector). Each button is synchronised
//   and debounced; a press gives one pulse, and holding the button gives
//   auto-repeat pulses after an initial delay.
//
// Ports
//   clk       system clock, all logic on posedge
//   rst_n     synchronous active-low reset
//   btn_up    raw asynchronous up button, active-high
//   btn_down  raw asynchronous down button, active-high
//   up        single-cycle step-up pulse
//   down      single-cycle step-down pulse
//   held      high while a single button is accepted as held (delay/repeat phase)
module button_step_gen #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int CNT_W           = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_up,
    input  logic btn_down,
    output logic up,
    output logic down,
    output logic held
);

    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    // Bit 0 = up button, bit 1 = down button throughout.
    logic [1:0]       raw_btn;
    logic [1:0]       sync1_reg;
    logic [1:0]       sync2_reg;
    logic [1:0]       deb_lvl_reg;
    logic [1:0]       deb_prev_reg;
    logic [1:0]       armed_reg;
    logic [CNT_W-1:0] deb_cnt_reg [2];

    // Shifts in ones after reset; once bit 1 is set, sync2_reg holds a genuine
    // sample of the pin rather than the reset value.
    logic [1:0]       sync_vld_reg;

    assign raw_btn = {btn_down, btn_up};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_vld_reg <= 2'b00;
        end else begin
            sync_vld_reg <= {sync_vld_reg[0], 1'b1};
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync1_reg[gi]    <= 1'b0;
                    sync2_reg[gi]    <= 1'b0;
                    deb_lvl_reg[gi]  <= 1'b0;
                    deb_prev_reg[gi] <= 1'b0;
                    armed_reg[gi]    <= 1'b0;
                    deb_cnt_reg[gi]  <= '0;
                end else begin
                    sync1_reg[gi]    <= raw_btn[gi];
                    sync2_reg[gi]    <= sync1_reg[gi];
                    deb_prev_reg[gi] <= deb_lvl_reg[gi];
                    // A button still held across reset must be seen released
                    // before it can be accepted again; until then the
                    // debouncer is parked at level 0.
                    if (!armed_reg[gi]) begin
                        deb_cnt_reg[gi] <= '0;
                        if (sync_vld_reg[1] && !sync2_reg[gi]) begin
                            armed_reg[gi] <= 1'b1;
                        end
                    end else if (sync2_reg[gi] == deb_lvl_reg[gi]) begin
                        deb_cnt_reg[gi] <= '0;
                    end else if (deb_cnt_reg[gi] == DEB_LAST) begin
                        deb_lvl_reg[gi] <= sync2_reg[gi];
                        deb_cnt_reg[gi] <= '0;
                    end else begin
                        deb_cnt_reg[gi] <= deb_cnt_reg[gi] + 1'b1;
                    end
                end
            end
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT,
        ST_LOCK
    } state_t;

    state_t           state_reg;
    logic             dir_reg;      // 0 = up, 1 = down
    logic [CNT_W-1:0] rcnt_reg;
    logic             up_reg;
    logic             down_reg;
    logic             held_reg;

    logic [1:0] rise;
    logic       dir_lvl;
    logic       opp_lvl;

    assign rise    = deb_lvl_reg & ~deb_prev_reg;
    assign dir_lvl = dir_reg ? deb_lvl_reg[1] : deb_lvl_reg[0];
    assign opp_lvl = dir_reg ? deb_lvl_reg[0] : deb_lvl_reg[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            dir_reg   <= 1'b0;
            rcnt_reg  <= '0;
            up_reg    <= 1'b0;
            down_reg  <= 1'b0;
            held_reg  <= 1'b0;
        end else begin
            up_reg   <= 1'b0;
            down_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    held_reg <= 1'b0;
                    if (deb_lvl_reg[0] && deb_lvl_reg[1]) begin
                        state_reg <= ST_LOCK;
                    end else if (rise[0]) begin
                        up_reg    <= 1'b1;
                        dir_reg   <= 1'b0;
                        rcnt_reg  <= '0;
                        held_reg  <= 1'b1;
                        state_reg <= ST_DELAY;
                    end else if (rise[1]) begin
                        down_reg  <= 1'b1;
                        dir_reg   <= 1'b1;
                        rcnt_reg  <= '0;
                        held_reg  <= 1'b1;
                        state_reg <= ST_DELAY;
                    end
                end
                ST_DELAY, ST_REPEAT: begin
                    // Opposite button wins over a simultaneous release so a
                    // chord always ends in LOCK and waits for both to clear.
                    if (opp_lvl) begin
                        held_reg  <= 1'b0;
                        state_reg <= ST_LOCK;
                    end else if (!dir_lvl) begin
                        held_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else if (rcnt_reg == ((state_reg == ST_DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
                        up_reg    <= ~dir_reg;
                        down_reg  <= dir_reg;
                        rcnt_reg  <= '0;
                        state_reg <= ST_REPEAT;
                    end else begin
                        rcnt_reg <= rcnt_reg + 1'b1;
                    end
                end
                ST_LOCK: begin
                    held_reg <= 1'b0;
                    if (!deb_lvl_reg[0] && !deb_lvl_reg[1]) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    held_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign up   = up_reg;
    assign down = down_reg;
    assign held = held_reg;

endmodule
